// File: rtl/except_ctrl_pkg.sv
// except_ctrl_pkg
// Shared definitions for the MEM-stage exception controller:
//   - CP0 register addresses used by the WB write bypass
//   - excepttype codes reported to CP0
//   - default exception handler entry PC
//   - controller state encoding
package except_ctrl_pkg;

    // CP0 register addresses
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;
    localparam logic [4:0] CP0_CONFIG  = 5'd16;

    // excepttype codes
    localparam logic [31:0] EXC_NONE         = 32'h0000_0000;
    localparam logic [31:0] EXC_INT          = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
    localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
    localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
    localparam logic [31:0] EXC_OV           = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

    // Default handler entry PC
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

    // Cause bits software may write: IP[1:0] (9:8), IV (23), WP (22)
    localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

    // mem_exc_i bit positions: {eret, overflow, trap, inst_invalid, syscall}
    localparam int EXC_BIT_SYSCALL      = 0;
    localparam int EXC_BIT_INST_INVALID = 1;
    localparam int EXC_BIT_TRAP         = 2;
    localparam int EXC_BIT_OV           = 3;
    localparam int EXC_BIT_ERET         = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/except_ctrl_exc_prio_enc.sv
// exc_prio_enc
// Combinational priority encoder turning the pending-interrupt flag and the
// MEM-stage exception flags into a single excepttype code.
// Ports:
//   int_pending  in   1   registered interrupt request
//   mem_exc      in   5   {eret, overflow, trap, inst_invalid, syscall}
//   code         out  32  excepttype code, 0 when nothing is raised
module exc_prio_enc
    import except_ctrl_pkg::*;
(
    input  logic        int_pending,
    input  logic [4:0]  mem_exc,
    output logic [31:0] code
);

    // Interrupts outrank every synchronous exception, eret is lowest.
    always_comb begin
        code = EXC_NONE;
        if (int_pending)
            code = EXC_INT;
        else if (mem_exc[EXC_BIT_SYSCALL])
            code = EXC_SYSCALL;
        else if (mem_exc[EXC_BIT_INST_INVALID])
            code = EXC_INST_INVALID;
        else if (mem_exc[EXC_BIT_TRAP])
            code = EXC_TRAP;
        else if (mem_exc[EXC_BIT_OV])
            code = EXC_OV;
        else if (mem_exc[EXC_BIT_ERET])
            code = EXC_ERET;
    end

endmodule

// File: rtl/except_ctrl.sv
// except_ctrl
// Commit-point exception controller sitting in MEM, upstream of CP0.
// Merges MEM exception flags with pending interrupts (seen through a bypass of
// any CP0 write still in WB), reports the exception to CP0 and sequences the
// pipeline flush with a redirect PC (handler vector, or EPC for eret).
// Ports:
//   clk, rst                clock, asynchronous active-low reset
//   mem_valid_i             real instruction in MEM
//   mem_pc_i                PC of MEM instruction
//   mem_in_delayslot_i      MEM instruction sits in a delay slot
//   mem_exc_i[4:0]          {eret, overflow, trap, inst_invalid, syscall}
//   stall_i                 MEM stalled this cycle
//   cp0_status/cause/epc_i  registered CP0 values
//   wb_cp0_we/waddr/data_i  CP0 write currently in WB
//   excepttype_o            exception code to CP0 (0 unless taken this cycle)
//   current_inst_addr_o     mem_pc_i pass-through
//   is_in_delayslot_o       mem_in_delayslot_i pass-through
//   flush_o, new_pc_o       flush request and redirect target
//   busy_o                  controller is in its flush sequence
// Handshake: an exception is taken only on a cycle where mem_valid_i=1,
// stall_i=0 and the controller is idle; excepttype_o is valid in that same
// cycle and flush_o/new_pc_o follow on the next cycle for FLUSH_CYCLES cycles.
module except_ctrl
    import except_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [4:0]  mem_exc_i,
    input  logic        stall_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o
);

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    ctrl_state_t state;
    logic [2:0]  flush_cnt;
    logic        int_pending;

    logic [31:0] eff_status;
    logic [31:0] eff_cause;
    logic [31:0] eff_epc;
    logic        int_cond;
    logic [31:0] code;
    logic        take;

    // CP0 values as they will be once the WB write lands.
    always_comb begin
        eff_status = cp0_status_i;
        eff_cause  = cp0_cause_i;
        eff_epc    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            if (wb_cp0_waddr_i == CP0_STATUS)
                eff_status = wb_cp0_data_i;
            if (wb_cp0_waddr_i == CP0_CAUSE)
                eff_cause = (cp0_cause_i & ~CAUSE_WMASK) | (wb_cp0_data_i & CAUSE_WMASK);
            if (wb_cp0_waddr_i == CP0_EPC)
                eff_epc = wb_cp0_data_i;
        end
    end

    // IE set, EXL clear, and some unmasked request line active.
    assign int_cond = eff_status[0] && !eff_status[1]
                      && (|(eff_cause[15:8] & eff_status[15:8]));

    // Only the bits feeding the interrupt test matter here.
    logic unused_cp0_bits;
    assign unused_cp0_bits = ^{eff_status[31:16], eff_status[7:2],
                               eff_cause[31:16], eff_cause[7:0]};

    exc_prio_enc u_prio (
        .int_pending (int_pending),
        .mem_exc     (mem_exc_i),
        .code        (code)
    );

    assign take = (state == ST_IDLE) && mem_valid_i && !stall_i && (code != EXC_NONE);

    assign excepttype_o        = take ? code : EXC_NONE;
    assign current_inst_addr_o = mem_pc_i;
    assign is_in_delayslot_o   = mem_in_delayslot_i;
    assign busy_o              = (state == ST_FLUSH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            flush_o     <= 1'b0;
            new_pc_o    <= 32'h0;
            int_pending <= 1'b0;
            flush_cnt   <= 3'd0;
        end else begin
            // The interrupt being taken is consumed; otherwise track the level.
            int_pending <= take ? 1'b0 : int_cond;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        state     <= ST_FLUSH;
                        flush_o   <= 1'b1;
                        flush_cnt <= FLUSH_LAST;
                        new_pc_o  <= (code == EXC_ERET) ? eff_epc : EXC_VECTOR;
                    end
                end
                ST_FLUSH: begin
                    // Anything raised now belongs to a squashed instruction.
                    if (flush_cnt == 3'd0) begin
                        state   <= ST_IDLE;
                        flush_o <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    flush_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_except_ctrl.sv
// tb_except_ctrl
// Scoreboard bench for except_ctrl: the driver applies one cycle of stimulus,
// a behavioural model decides whether that cycle commits an exception and
// queues the expected report; a negedge monitor checks the DUT against it.
module tb_except_ctrl;

    localparam int          FC     = 3;
    localparam logic [31:0] VECTOR = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delayslot_i;
    logic [4:0]  mem_exc_i;
    logic        stall_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        busy_o;

    except_ctrl #(.EXC_VECTOR(VECTOR), .FLUSH_CYCLES(FC)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .mem_valid_i         (mem_valid_i),
        .mem_pc_i            (mem_pc_i),
        .mem_in_delayslot_i  (mem_in_delayslot_i),
        .mem_exc_i           (mem_exc_i),
        .stall_i             (stall_i),
        .cp0_status_i        (cp0_status_i),
        .cp0_cause_i         (cp0_cause_i),
        .cp0_epc_i           (cp0_epc_i),
        .wb_cp0_we_i         (wb_cp0_we_i),
        .wb_cp0_waddr_i      (wb_cp0_waddr_i),
        .wb_cp0_data_i       (wb_cp0_data_i),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o),
        .busy_o              (busy_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- counters / compare ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected entry: [128:97] cycle, [96:65] code, [64:33] pc, [32] ds, [31:0] new_pc
    logic [128:0] exp_q[$];
    bit m_pend = 1'b0;   // an interrupt request has been seen on the previous cycle
    int m_busy = 0;      // flush cycles still to come before the next commit may happen

    // Priority of the exception flags, listed highest first by bit position.
    int          prio_bit[5]  = '{0, 1, 2, 3, 4};
    logic [31:0] prio_code[5] = '{32'h8, 32'ha, 32'hd, 32'hc, 32'he};

    task automatic model_step();
        logic [31:0] st, ca, ep, code;
        logic [31:0] cmask;
        bit cond, commit;
        st = cp0_status_i;
        ca = cp0_cause_i;
        ep = cp0_epc_i;
        cmask = 32'h00C0_0300;
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) st = wb_cp0_data_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) ca = (ca & ~cmask) | (wb_cp0_data_i & cmask);
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) ep = wb_cp0_data_i;
        cond = (st[0] == 1'b1) && (st[1] == 1'b0) && (((ca >> 8) & (st >> 8) & 32'hff) != 0);

        code = 32'h0;
        if (m_pend) code = 32'h1;
        else
            for (int i = 0; i < 5; i++)
                if (code == 0 && mem_exc_i[prio_bit[i]]) code = prio_code[i];

        commit = (m_busy == 0) && mem_valid_i && !stall_i && (code != 0);
        if (commit) begin
            exp_q.push_back({32'(cyc), code, mem_pc_i, mem_in_delayslot_i,
                             (code == 32'he) ? ep : VECTOR});
            m_busy = FC;
        end else if (m_busy > 0) begin
            m_busy = m_busy - 1;
        end
        m_pend = commit ? 1'b0 : cond;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [31:0] pc, input logic ds,
                         input logic [4:0] exc, input logic st,
                         input logic [31:0] status, input logic [31:0] cause,
                         input logic [31:0] epc, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd);
        @(posedge clk);
        #1;
        mem_valid_i        = v;
        mem_pc_i           = pc;
        mem_in_delayslot_i = ds;
        mem_exc_i          = exc;
        stall_i            = st;
        cp0_status_i       = status;
        cp0_cause_i        = cause;
        cp0_epc_i          = epc;
        wb_cp0_we_i        = we;
        wb_cp0_waddr_i     = wa;
        wb_cp0_data_i      = wd;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 32'h0, 1'b0, 5'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic set_idle_inputs();
        mem_valid_i = 0; mem_pc_i = 0; mem_in_delayslot_i = 0; mem_exc_i = 0;
        stall_i = 0; cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
        wb_cp0_we_i = 0; wb_cp0_waddr_i = 0; wb_cp0_data_i = 0;
    endtask

    // ---------------- monitor ----------------
    bit           mon_en = 1'b0;
    int           flush_left = 0;
    logic [31:0]  mon_npc;
    logic [128:0] e;

    always @(negedge clk) begin
        if (!mon_en) begin
            flush_left = 0;
        end else begin
            while (exp_q.size() > 0 && int'(exp_q[0][128:97]) < cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL missed_take: got no exception expected code %h at cycle %0d",
                         exp_q[0][96:65], exp_q[0][128:97]);
                void'(exp_q.pop_front());
            end
            if (flush_left > 0) begin
                chk("flush_high", {31'b0, flush_o}, 32'h1);
                chk("busy_high", {31'b0, busy_o}, 32'h1);
                chk("new_pc", new_pc_o, mon_npc);
                chk("excepttype_while_busy", excepttype_o, 32'h0);
                flush_left--;
            end else begin
                chk("flush_low", {31'b0, flush_o}, 32'h0);
                chk("busy_low", {31'b0, busy_o}, 32'h0);
                if (excepttype_o != 0) begin
                    if (exp_q.size() == 0 || int'(exp_q[0][128:97]) != cyc) begin
                        chk("spurious_take", excepttype_o, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("excepttype", excepttype_o, e[96:65]);
                        chk("inst_addr", current_inst_addr_o, e[64:33]);
                        chk("delayslot", {31'b0, is_in_delayslot_o}, {31'b0, e[32]});
                        mon_npc    = e[31:0];
                        flush_left = FC;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [4:0] waddr_tbl[5] = '{5'd12, 5'd13, 5'd14, 5'd9, 5'd11};

    initial begin
        logic [31:0] st, ca;
        int r;
        set_idle_inputs();
        rst = 1'b0;
        #12;
        chk("reset_flush", {31'b0, flush_o}, 32'h0);
        chk("reset_new_pc", new_pc_o, 32'h0);
        chk("reset_busy", {31'b0, busy_o}, 32'h0);
        chk("reset_excepttype", excepttype_o, 32'h0);
        #11 rst = 1'b1;
        mon_en = 1'b1;

        // syscall, not in delay slot
        drive(1, 32'h100, 0, 5'b00001, 0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
        idle(FC + 1);
        // overflow in a delay slot
        drive(1, 32'h204, 1, 5'b01000, 0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
        idle(FC + 1);
        // interrupt: two bubbles then a real instruction
        drive(0, 32'h0, 0, 5'b0, 0, 32'h401, 32'h400, 32'h0, 0, 5'd0, 32'h0);
        drive(0, 32'h0, 0, 5'b0, 0, 32'h401, 32'h400, 32'h0, 0, 5'd0, 32'h0);
        drive(1, 32'h300, 0, 5'b0, 0, 32'h401, 32'h400, 32'h0, 0, 5'd0, 32'h0);
        idle(FC + 1);
        // eret with EPC rewritten in WB the same cycle
        drive(1, 32'h380, 0, 5'b10000, 0, 32'h0, 32'h0, 32'h1000, 1, 5'd14, 32'h2000);
        idle(FC + 1);
        // trap then inst_invalid on the next cycle: only the trap commits
        drive(1, 32'h400, 0, 5'b00100, 0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
        drive(1, 32'h404, 0, 5'b00010, 0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
        idle(FC + 1);
        // stalled syscall held off, then released
        drive(1, 32'h480, 0, 5'b00001, 1, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
        drive(1, 32'h480, 0, 5'b00001, 0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
        idle(FC + 1);
        // EXL set by WB in the same cycle masks the interrupt
        drive(0, 32'h0, 0, 5'b0, 0, 32'h401, 32'h400, 32'h0, 1, 5'd12, 32'h403);
        drive(1, 32'h500, 0, 5'b0, 0, 32'h403, 32'h400, 32'h0, 0, 5'd0, 32'h0);
        idle(2);
        // interrupt and eret together: interrupt wins, vector not EPC
        drive(0, 32'h0, 0, 5'b0, 0, 32'h401, 32'h400, 32'h0, 0, 5'd0, 32'h0);
        drive(1, 32'h540, 0, 5'b10000, 0, 32'h401, 32'h400, 32'h3000, 0, 5'd0, 32'h0);
        idle(FC + 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            st = $urandom;
            st[1] = ($urandom_range(0, 3) == 0);
            ca = $urandom & $urandom;
            r = $urandom_range(0, 9);
            drive($urandom_range(0, 4) != 0, {$urandom_range(0, 65535), 2'b00}, 1'($urandom_range(0, 1)),
                  (r < 5) ? 5'(1 << r) : 5'b0, $urandom_range(0, 4) == 0,
                  st, ca, {$urandom_range(0, 65535), 2'b00}, $urandom_range(0, 2) == 0,
                  waddr_tbl[$urandom_range(0, 4)], $urandom);
        end
        idle(FC + 2);

        // reset in the second flush cycle
        drive(1, 32'h600, 0, 5'b00001, 0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
        idle(2);
        #1;
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("midflush_reset_flush", {31'b0, flush_o}, 32'h0);
        chk("midflush_reset_new_pc", new_pc_o, 32'h0);
        chk("midflush_reset_busy", {31'b0, busy_o}, 32'h0);
        set_idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        m_pend = 1'b0;
        m_busy = 0;
        chk("queue_empty_at_reset", exp_q.size(), 32'h0);
        exp_q.delete();
        mon_en = 1'b1;
        idle(1);
        chk("after_reset_busy", {31'b0, busy_o}, 32'h0);
        chk("after_reset_flush", {31'b0, flush_o}, 32'h0);
        drive(1, 32'h700, 1, 5'b00100, 0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
        idle(FC + 2);

        chk("queue_drained", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
